circuito_exp7: RTL and testbench
================================

CIRCUITO_EXP7 -- requirements
Module: circuito_exp7

Interface
REQ-001 Parameters SHALL be: SHOW_CYCLES, default 1000, clocks the first play is shown on leds; TIMEOUT_CYCLES, default 5000, maximum clocks allowed waiting for a button.
REQ-002 clock  in  1  system clock, all state on rising edge.
REQ-003 reset  in  1  one clock; reset is asynchronous and active-low.
REQ-004 iniciar  in  1  level, starts a game from inicial or any final state.
REQ-005 botoes  in  4  one-hot player buttons, 4'b0000 = none.
REQ-006 leds  out  4  play display.
REQ-007 pronto / ganhou / perdeu  out  1 each  game finished / won / lost.
REQ-008 db_clock, db_tem_jogada, db_igual, db_enderecoIgualRodada, db_timeout  out  1 each  debug: clock copy, button edge pulse, comparator, endereco==rodada, timeout flag.
REQ-009 db_contagem (endereco), db_memoria (RAM data), db_jogadafeita (registered play), db_rodada, db_estado  out  7 each  hex 7-seg, active-low, bit order gfedcba, nibble 0-F.

Function
REQ-010 Memory SHALL be a 16x4 RAM with contents after reset: address 0 = 4'b0001, addresses 1-15 = 4'b0000; contents SHALL persist across games.
REQ-011 A play SHALL be the rising edge of OR(botoes), registered one cycle; botoes SHALL be latched into jogadafeita on that edge; held buttons SHALL count once.
REQ-012 FSM state codes (db_estado) SHALL be: inicial 0, preparacao 1, mostra 2, espera_jogada 3, registra 4, compara 5, proxima_jogada 6, espera_escrita 7, escreve 8, proxima_rodada 9, fim_ganhou A, fim_perdeu E, fim_timeout F.
REQ-013 inicial: wait for iniciar=1 -> preparacao (clear endereco, rodada, jogadafeita, timer) -> mostra.
REQ-014 mostra: leds = RAM[0] for SHOW_CYCLES clocks -> espera_jogada.
REQ-015 espera_jogada: play -> registra -> compara; mismatch -> fim_perdeu; match and endereco<rodada -> proxima_jogada (endereco+1) -> espera_jogada; match and endereco==rodada -> fim_ganhou if rodada==15, else espera_escrita.
REQ-016 espera_escrita: play -> escreve (RAM[rodada+1] <= jogadafeita) -> proxima_rodada (rodada+1, endereco=0) -> espera_jogada; no replay display between rounds.
REQ-017 Timer SHALL clear on entry to espera_jogada/espera_escrita; TIMEOUT_CYCLES clocks without a play -> fim_timeout, db_timeout=1.
REQ-018 Final states: pronto=1; fim_ganhou ganhou=1; fim_perdeu and fim_timeout perdeu=1; held until iniciar=1 -> preparacao.
REQ-019 leds SHALL equal botoes in espera/registra states, RAM[0] in mostra, 0 otherwise.
REQ-020 Counters endereco and rodada are 4-bit; rodada SHALL never exceed 15 (ganhou instead of increment).
REQ-021 Simultaneous multi-bit botoes SHALL be registered as-is and compared bitwise (mismatch -> perdeu).

Reset
REQ-022 Asynchronous reset SHALL force inicial, endereco=rodada=0, jogadafeita=0, timer=0, RAM to REQ-010 contents; all single-bit outputs 0, leds 0.
REQ-023 Reset mid-game SHALL abort immediately; no output state survives.

Structure
REQ-024 A shared package SHALL hold the state encoding constants, SHOW_CYCLES/TIMEOUT_CYCLES defaults and the 7-seg decode table.
REQ-025 Split into unidade_controle (FSM) and fluxo_dados (counters, RAM, comparator, edge detector, timer); one sub-module hexa7seg instanced five times.

Verification
REQ-026 Reset, iniciar 5 clocks, wait 2000 clocks -> leds showed 4'b0001, state espera_jogada (3), db_rodada "0".
REQ-027 Win: each round repeat 0001,0100,0001,1000,1000,0100,0100,0010,0010,0001,0001,0010,0100,1000,0100,0100 prefix, writing next value after each round, 10-clock presses, 10-clock gaps -> ganhou=1, pronto=1, state A after round 16.
REQ-028 Lose: round 3, play 2, press 0001 (expected 0100) -> perdeu=1, pronto=1, ganhou=0, state E.
REQ-029 Timeout: after start, no button for TIMEOUT_CYCLES -> db_timeout=1, perdeu=1, state F.
REQ-030 Button held 10 clocks -> exactly one db_tem_jogada pulse; reset asserted mid-round -> state 0, outputs 0.

Source files
------------

// File: rtl/circuito_exp7_pkg.sv
// Shared definitions for the memory game: FSM state codes, timing defaults,
// datapath control bundle and the active-low 7-segment decode table.
package circuito_exp7_pkg;

   localparam int SHOW_CYCLES_DEF    = 1000;
   localparam int TIMEOUT_CYCLES_DEF = 5000;

   localparam logic [3:0] MEM_INIT0  = 4'b0001;
   localparam logic [3:0] RODADA_MAX = 4'hF;

   typedef enum logic [3:0] {
      ST_INICIAL        = 4'h0,
      ST_PREPARACAO     = 4'h1,
      ST_MOSTRA         = 4'h2,
      ST_ESPERA_JOGADA  = 4'h3,
      ST_REGISTRA       = 4'h4,
      ST_COMPARA        = 4'h5,
      ST_PROXIMA_JOGADA = 4'h6,
      ST_ESPERA_ESCRITA = 4'h7,
      ST_ESCREVE        = 4'h8,
      ST_PROXIMA_RODADA = 4'h9,
      ST_FIM_GANHOU     = 4'hA,
      ST_FIM_PERDEU     = 4'hE,
      ST_FIM_TIMEOUT    = 4'hF
   } estado_t;

   typedef struct packed {
      logic zera;
      logic conta_endereco;
      logic proxima_rodada;
      logic escreve;
      logic conta_mostra;
      logic conta_timer;
      logic leds_botoes;
      logic leds_mem;
   } ctrl_t;

   // Segment order gfedcba, a lit segment drives 0.
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
      return SEG_TABLE[nibble];
   endfunction

endpackage

// File: rtl/fluxo_dados.sv
// Game datapath: play edge detector, sequence RAM, address/round counters,
// display and wait timers, comparator and led mux.
module fluxo_dados
   import circuito_exp7_pkg::*;
#(
   parameter int SHOW_CYCLES    = SHOW_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] botoes,
   input  ctrl_t      ctrl,
   output logic       tem_jogada,
   output logic       igual,
   output logic       endereco_igual_rodada,
   output logic       rodada_max,
   output logic       fim_mostra,
   output logic       timeout,
   output logic [3:0] leds,
   output logic [3:0] endereco,
   output logic [3:0] rodada,
   output logic [3:0] dado_mem,
   output logic [3:0] jogadafeita
);

   localparam int SW = $clog2(SHOW_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic          btn_or_p0;
   logic          btn_or_p1;
   logic          borda_p0;
   logic [SW-1:0] cnt_mostra;
   logic [TW-1:0] timer;
   logic [3:0]    mem [16];

   assign btn_or_p0 = |botoes;
   assign borda_p0  = btn_or_p0 & ~btn_or_p1;

   // p0 -> p1: rising edge of any button; held buttons produce a single pulse
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         btn_or_p1   <= 1'b0;
         tem_jogada  <= 1'b0;
         jogadafeita <= 4'b0000;
      end else begin
         btn_or_p1  <= btn_or_p0;
         tem_jogada <= borda_p0;
         if (ctrl.zera)
            jogadafeita <= 4'b0000;
         else if (borda_p0)
            jogadafeita <= botoes;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         endereco <= 4'd0;
         rodada   <= 4'd0;
      end else if (ctrl.zera) begin
         endereco <= 4'd0;
         rodada   <= 4'd0;
      end else if (ctrl.conta_endereco) begin
         endereco <= endereco + 4'd1;
      end else if (ctrl.proxima_rodada) begin
         endereco <= 4'd0;
         rodada   <= rodada + 4'd1;
      end
   end

   // Both timers restart whenever their owning state is left.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_mostra <= '0;
         timer      <= '0;
      end else begin
         cnt_mostra <= ctrl.conta_mostra ? cnt_mostra + SW'(1) : '0;
         timer      <= (ctrl.conta_timer && !ctrl.zera) ? timer + TW'(1) : '0;
      end
   end

   assign fim_mostra = ctrl.conta_mostra && (cnt_mostra == SW'(SHOW_CYCLES - 1));
   assign timeout    = ctrl.conta_timer && (timer == TW'(TIMEOUT_CYCLES - 1));

   // The sequence survives between games; only reset restores the seed.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 16; i++)
            mem[i] <= (i == 0) ? MEM_INIT0 : 4'b0000;
      end else if (ctrl.escreve) begin
         mem[rodada + 4'd1] <= jogadafeita;
      end
   end

   assign dado_mem              = mem[endereco];
   assign igual                 = (dado_mem == jogadafeita);
   assign endereco_igual_rodada = (endereco == rodada);
   assign rodada_max            = (rodada == RODADA_MAX);

   always_comb begin
      leds = 4'b0000;
      if (ctrl.leds_botoes)
         leds = botoes;
      else if (ctrl.leds_mem)
         leds = mem[0];
   end

endmodule

// File: rtl/hexa7seg.sv
// Nibble to active-low 7-segment display decoder.
module hexa7seg
   import circuito_exp7_pkg::*;
(
   input  logic [3:0] hexa,
   output logic [6:0] display
);

   assign display = hex_to_seg(hexa);

endmodule

// File: rtl/unidade_controle.sv
// Game sequencer FSM with registered result flags; datapath strobes are a
// Moore decode of the state register.
module unidade_controle
   import circuito_exp7_pkg::*;
(
   input  logic    clock,
   input  logic    reset,
   input  logic    iniciar,
   input  logic    tem_jogada,
   input  logic    igual,
   input  logic    endereco_igual_rodada,
   input  logic    rodada_max,
   input  logic    fim_mostra,
   input  logic    timeout,
   output estado_t estado,
   output ctrl_t   ctrl,
   output logic    pronto,
   output logic    ganhou,
   output logic    perdeu,
   output logic    db_timeout
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado     <= ST_INICIAL;
         pronto     <= 1'b0;
         ganhou     <= 1'b0;
         perdeu     <= 1'b0;
         db_timeout <= 1'b0;
      end else begin
         case (estado)
            ST_INICIAL:
               if (iniciar) estado <= ST_PREPARACAO;
            ST_PREPARACAO:
               estado <= ST_MOSTRA;
            ST_MOSTRA:
               if (fim_mostra) estado <= ST_ESPERA_JOGADA;
            ST_ESPERA_JOGADA, ST_ESPERA_ESCRITA: begin
               if (tem_jogada) begin
                  estado <= (estado == ST_ESPERA_JOGADA) ? ST_REGISTRA : ST_ESCREVE;
               end else if (timeout) begin
                  estado     <= ST_FIM_TIMEOUT;
                  pronto     <= 1'b1;
                  perdeu     <= 1'b1;
                  db_timeout <= 1'b1;
               end
            end
            ST_REGISTRA:
               estado <= ST_COMPARA;
            ST_COMPARA: begin
               if (!igual) begin
                  estado <= ST_FIM_PERDEU;
                  pronto <= 1'b1;
                  perdeu <= 1'b1;
               end else if (!endereco_igual_rodada) begin
                  estado <= ST_PROXIMA_JOGADA;
               end else if (rodada_max) begin
                  estado <= ST_FIM_GANHOU;
                  pronto <= 1'b1;
                  ganhou <= 1'b1;
               end else begin
                  estado <= ST_ESPERA_ESCRITA;
               end
            end
            ST_PROXIMA_JOGADA:
               estado <= ST_ESPERA_JOGADA;
            ST_ESCREVE:
               estado <= ST_PROXIMA_RODADA;
            ST_PROXIMA_RODADA:
               estado <= ST_ESPERA_JOGADA;
            ST_FIM_GANHOU, ST_FIM_PERDEU, ST_FIM_TIMEOUT: begin
               if (iniciar) begin
                  estado     <= ST_PREPARACAO;
                  pronto     <= 1'b0;
                  ganhou     <= 1'b0;
                  perdeu     <= 1'b0;
                  db_timeout <= 1'b0;
               end
            end
            default:
               estado <= ST_INICIAL;
         endcase
      end
   end

   always_comb begin
      ctrl                = '0;
      ctrl.zera           = (estado == ST_PREPARACAO);
      ctrl.conta_endereco = (estado == ST_PROXIMA_JOGADA);
      ctrl.proxima_rodada = (estado == ST_PROXIMA_RODADA);
      ctrl.escreve        = (estado == ST_ESCREVE);
      ctrl.conta_mostra   = (estado == ST_MOSTRA);
      ctrl.conta_timer    = (estado == ST_ESPERA_JOGADA) || (estado == ST_ESPERA_ESCRITA);
      ctrl.leds_botoes    = ctrl.conta_timer || (estado == ST_REGISTRA);
      ctrl.leds_mem       = (estado == ST_MOSTRA);
   end

endmodule

// File: rtl/circuito_exp7.sv
// Memory game top: controller, datapath and five debug hex displays.
module circuito_exp7
   import circuito_exp7_pkg::*;
#(
   parameter int SHOW_CYCLES    = SHOW_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic [3:0] botoes,
   output logic [3:0] leds,
   output logic       pronto,
   output logic       ganhou,
   output logic       perdeu,
   output logic       db_clock,
   output logic       db_tem_jogada,
   output logic       db_igual,
   output logic       db_enderecoIgualRodada,
   output logic       db_timeout,
   output logic [6:0] db_contagem,
   output logic [6:0] db_memoria,
   output logic [6:0] db_jogadafeita,
   output logic [6:0] db_rodada,
   output logic [6:0] db_estado
);

   estado_t    estado;
   ctrl_t      ctrl;
   logic       tem_jogada;
   logic       igual;
   logic       endereco_igual_rodada;
   logic       rodada_max;
   logic       fim_mostra;
   logic       timeout;
   logic [3:0] endereco;
   logic [3:0] rodada;
   logic [3:0] dado_mem;
   logic [3:0] jogadafeita;

   unidade_controle u_uc (
      .clock                 (clock),
      .reset                 (reset),
      .iniciar               (iniciar),
      .tem_jogada            (tem_jogada),
      .igual                 (igual),
      .endereco_igual_rodada (endereco_igual_rodada),
      .rodada_max            (rodada_max),
      .fim_mostra            (fim_mostra),
      .timeout               (timeout),
      .estado                (estado),
      .ctrl                  (ctrl),
      .pronto                (pronto),
      .ganhou                (ganhou),
      .perdeu                (perdeu),
      .db_timeout            (db_timeout)
   );

   fluxo_dados #(
      .SHOW_CYCLES    (SHOW_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_fd (
      .clock                 (clock),
      .reset                 (reset),
      .botoes                (botoes),
      .ctrl                  (ctrl),
      .tem_jogada            (tem_jogada),
      .igual                 (igual),
      .endereco_igual_rodada (endereco_igual_rodada),
      .rodada_max            (rodada_max),
      .fim_mostra            (fim_mostra),
      .timeout               (timeout),
      .leds                  (leds),
      .endereco              (endereco),
      .rodada                (rodada),
      .dado_mem              (dado_mem),
      .jogadafeita           (jogadafeita)
   );

   assign db_clock               = clock;
   assign db_tem_jogada          = tem_jogada;
   assign db_igual               = igual;
   assign db_enderecoIgualRodada = endereco_igual_rodada;

   hexa7seg u_hex_contagem (.hexa(endereco),    .display(db_contagem));
   hexa7seg u_hex_memoria  (.hexa(dado_mem),    .display(db_memoria));
   hexa7seg u_hex_jogada   (.hexa(jogadafeita), .display(db_jogadafeita));
   hexa7seg u_hex_rodada   (.hexa(rodada),      .display(db_rodada));
   hexa7seg u_hex_estado   (.hexa(estado),      .display(db_estado));

endmodule

// File: tb/tb_circuito_exp7.sv
// Randomized bench for the memory game: a game-rule model predicts each
// game's outcome into a queue that a monitor drains when pronto rises.
module tb_circuito_exp7;

   localparam int SHOW = 1000;
   localparam int TOUT = 5000;

   logic       clock = 1'b0;
   logic       reset;
   logic       iniciar;
   logic [3:0] botoes;
   logic [3:0] leds;
   logic       pronto, ganhou, perdeu;
   logic       db_clock, db_tem_jogada, db_igual, db_enderecoIgualRodada, db_timeout;
   logic [6:0] db_contagem, db_memoria, db_jogadafeita, db_rodada, db_estado;

   circuito_exp7 #(.SHOW_CYCLES(SHOW), .TIMEOUT_CYCLES(TOUT)) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .botoes(botoes), .leds(leds),
      .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu), .db_clock(db_clock),
      .db_tem_jogada(db_tem_jogada), .db_igual(db_igual),
      .db_enderecoIgualRodada(db_enderecoIgualRodada), .db_timeout(db_timeout),
      .db_contagem(db_contagem), .db_memoria(db_memoria), .db_jogadafeita(db_jogadafeita),
      .db_rodada(db_rodada), .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       ganhou;
      logic       perdeu;
      logic [3:0] estado;
      logic       timeout;
      string      tag;
   } exp_t;

   exp_t       exp_q[$];
   int         checks = 0;
   int         failures = 0;
   int         pulse_total = 0;
   int         presses = 0;
   bit         mostra_seen, mostra_bad;
   logic [3:0] mem_m [16];
   logic [6:0] seg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic [3:0] win_seq [16] = '{4'b0001, 4'b0100, 4'b0001, 4'b1000, 4'b1000, 4'b0100,
                                4'b0100, 4'b0010, 4'b0010, 4'b0001, 4'b0001, 4'b0010,
                                4'b0100, 4'b1000, 4'b0100, 4'b0100};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic mem_init();
      for (int i = 0; i < 16; i++) mem_m[i] = (i == 0) ? 4'b0001 : 4'b0000;
   endtask

   task automatic push_exp(input logic g, input logic p, input logic [3:0] st,
                           input logic to, input string tag);
      exp_t e;
      e.ganhou = g; e.perdeu = p; e.estado = st; e.timeout = to; e.tag = tag;
      exp_q.push_back(e);
   endtask

   task automatic monitor_loop();
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clock);
         if (!reset) begin
            prev = 1'b0;
         end else begin
            if (db_tem_jogada) pulse_total++;
            if (db_estado == seg[2]) begin
               mostra_seen = 1'b1;
               if (leds !== 4'b0001) mostra_bad = 1'b1;
            end
            if (pronto && !prev) begin
               chk("expect_queued", 32'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk({e.tag, "_ganhou"}, ganhou, e.ganhou);
                  chk({e.tag, "_perdeu"}, perdeu, e.perdeu);
                  chk({e.tag, "_estado"}, db_estado, seg[e.estado]);
                  chk({e.tag, "_timeout"}, db_timeout, e.timeout);
               end
            end
            prev = pronto;
         end
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_estado"}, db_estado, seg[0]);
      chk({tag, "_pronto"}, pronto, 0);
      chk({tag, "_ganhou"}, ganhou, 0);
      chk({tag, "_perdeu"}, perdeu, 0);
      chk({tag, "_timeout"}, db_timeout, 0);
      chk({tag, "_leds"}, leds, 0);
      chk({tag, "_rodada"}, db_rodada, seg[0]);
      chk({tag, "_contagem"}, db_contagem, seg[0]);
      chk({tag, "_jogada"}, db_jogadafeita, seg[0]);
      chk({tag, "_mem0"}, db_memoria, seg[1]);
   endtask

   task automatic press(input logic [3:0] v);
      botoes = v;
      #1;
      chk("press_in_espera", 32'(db_estado == seg[3] || db_estado == seg[7]), 1);
      chk("leds_follow_botoes", leds, v);
      cyc(10);
      botoes = 4'b0000;
      cyc(10);
      presses++;
   endtask

   // Plays one game by the rules: rounds r=0..15, plays 0..r, then a write.
   // fail_* injects a wrong play, to_* stops pressing, rst_r resets mid-round.
   task automatic run_game(input int fail_r, input int fail_p, input logic [3:0] fail_v,
                           input int to_r, input int to_p, input int rst_r,
                           input bit use_seq, input bit chk_start);
      int         p0;
      bit         ok, done, was_reset;
      logic [3:0] v;
      p0 = pulse_total;
      presses = 0;
      done = 0;
      was_reset = 0;
      mostra_seen = 0;
      mostra_bad = 0;
      iniciar = 1'b1;
      cyc(5);
      iniciar = 1'b0;
      if (chk_start) begin
         cyc(2000);
         chk("start_estado", db_estado, seg[3]);
         chk("start_rodada", db_rodada, seg[0]);
      end else begin
         ok = 0;
         for (int k = 0; k < SHOW + 50 && !ok; k++) begin
            if (db_estado == seg[3]) ok = 1;
            else cyc(1);
         end
         chk("reach_espera", ok, 1);
      end
      chk("mostra_seen", mostra_seen, 1);
      chk("mostra_leds_0001", mostra_bad, 0);
      for (int r = 0; r < 16 && !done; r++) begin
         for (int i = 0; i <= r + 1 && !done; i++) begin
            if (r == rst_r && i == 0) begin
               botoes = mem_m[0];
               cyc(3);
               #2 reset = 1'b0;
               #1 check_idle("midreset");
               botoes = 4'b0000;
               cyc(2);
               reset = 1'b1;
               mem_init();
               done = 1;
               was_reset = 1;
            end else if (r == to_r && i == to_p) begin
               push_exp(0, 1, 4'hF, 1, "timeout");
               done = 1;
            end else if (i <= r) begin
               if (r == fail_r && i == fail_p) begin
                  v = fail_v;
                  while (v == 4'b0000 || v == mem_m[i]) v = 4'($urandom_range(1, 15));
                  push_exp(0, 1, 4'hE, 0, "perdeu");
                  press(v);
                  done = 1;
               end else begin
                  if (r == 15 && i == 15) begin
                     push_exp(1, 0, 4'hA, 0, "ganhou");
                     done = 1;
                  end
                  press(mem_m[i]);
               end
            end else begin
               v = use_seq ? win_seq[r + 1] : 4'($urandom_range(1, 15));
               mem_m[r + 1] = v;
               press(v);
            end
         end
      end
      if (!was_reset) begin
         ok = 0;
         for (int k = 0; k < TOUT + 500 && !ok; k++) begin
            if (pronto) ok = 1;
            else cyc(1);
         end
         chk("pronto_seen", ok, 1);
         cyc(3);
         chk("one_pulse_per_press", 32'(pulse_total - p0), 32'(presses));
      end
      chk("queue_drained", 32'(exp_q.size()), 0);
      exp_q.delete();
   endtask

   initial begin
      int kind, r, p;
      reset = 1'b0;
      iniciar = 1'b0;
      botoes = 4'b0000;
      mem_init();
      fork
         monitor_loop();
      join_none
      cyc(3);
      check_idle("reset");
      reset = 1'b1;
      cyc(2);
      run_game(-1, -1, 4'b0000, -1, -1, -1, 1'b1, 1'b1);
      run_game(2, 1, 4'b0001, -1, -1, -1, 1'b1, 1'b0);
      run_game(-1, -1, 4'b0000, 0, 0, -1, 1'b1, 1'b0);
      for (int g = 0; g < 4; g++) begin
         kind = int'($urandom_range(0, 1));
         r = int'($urandom_range(0, 4));
         if (kind == 0) begin
            p = int'($urandom_range(0, r));
            run_game(r, p, 4'b0000, -1, -1, -1, 1'b0, 1'b0);
         end else begin
            p = int'($urandom_range(0, r + 1));
            run_game(-1, -1, 4'b0000, r, p, -1, 1'b0, 1'b0);
         end
      end
      run_game(-1, -1, 4'b0000, -1, -1, 2, 1'b0, 1'b0);
      run_game(1, 1, 4'b0000, -1, -1, -1, 1'b0, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
